// File: rtl/input_port.sv
// NoC router input port: one flit FIFO per virtual channel, each with an IDLE/VA/ACTIVE packet FSM
// and XY route computation. Define INPUT_PORT_PROTOCOL_CHECK_EN for simulation protocol error reports.
package noc_params;
  localparam int MESH_SIZE_X       = 4;
  localparam int MESH_SIZE_Y       = 4;
  localparam int DEST_ADDR_SIZE_X  = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y  = $clog2(MESH_SIZE_Y);
  localparam int VC_NUM            = 4;
  localparam int VC_SIZE           = $clog2(VC_NUM);
  localparam int FLIT_DATA_SIZE    = 16;
  localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;
endpackage

// Handshake: a flit is written when valid_flit_i=1 at a rising edge and the target VC accepts it;
// a flit is popped when valid_sel_i=1 at a rising edge and VC vc_sel_i is ACTIVE and non-empty.
module input_port
  import noc_params::*;
#(
  parameter int BUFFER_SIZE    = 8,
  parameter int PIPELINE_DEPTH = 5,
  parameter int X_CURRENT      = MESH_SIZE_X / 2,
  parameter int Y_CURRENT      = MESH_SIZE_Y / 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  flit_t                            data_i,
  input  logic                             valid_flit_i,
  input  logic [VC_SIZE-1:0]               vc_sel_i,
  input  logic                             valid_sel_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]   vc_new_i,
  input  logic [VC_NUM-1:0]                vc_valid_i,
  output flit_t                            flit_o,
  output logic [VC_NUM-1:0]                on_off_o,
  output logic [VC_NUM-1:0]                vc_allocatable_o,
  output logic [VC_NUM-1:0]                vc_request_o,
  output port_t [VC_NUM-1:0]               out_port_o,
  output logic [VC_NUM-1:0]                is_full_o,
  output logic [VC_NUM-1:0]                is_empty_o
);

  typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_e;

  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_SIZE - 1);

  vc_state_e          state_q    [VC_NUM];
  logic [PTR_W-1:0]   rd_ptr_q   [VC_NUM];
  logic [PTR_W-1:0]   wr_ptr_q   [VC_NUM];
  logic [CNT_W-1:0]   cnt_q      [VC_NUM];
  logic [VC_SIZE-1:0] down_vc_q  [VC_NUM];
  port_t              out_port_q [VC_NUM];
  logic [VC_NUM-1:0]  tail_in_q;
  flit_t              mem_q      [VC_NUM][BUFFER_SIZE];

  logic [VC_NUM-1:0] wr_en;
  logic [VC_NUM-1:0] rd_en;
  logic [VC_NUM-1:0] front_last;
  logic              is_head;
  port_t             route;

  assign is_head = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);

  always_comb begin
    route = LOCAL;
    if (int'(data_i.data.head_data.x_dest) > X_CURRENT)      route = EAST;
    else if (int'(data_i.data.head_data.x_dest) < X_CURRENT) route = WEST;
    else if (int'(data_i.data.head_data.y_dest) > Y_CURRENT) route = SOUTH;
    else if (int'(data_i.data.head_data.y_dest) < Y_CURRENT) route = NORTH;
  end

  // tail_in_q marks that the packet's last flit is already buffered, so later flits are stray
  always_comb begin
    wr_en      = '0;
    rd_en      = '0;
    front_last = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (valid_flit_i && (data_i.vc_id == VC_SIZE'(v))) begin
        if (state_q[v] == IDLE) wr_en[v] = is_head;
        else wr_en[v] = !is_head && !tail_in_q[v] && (cnt_q[v] != CNT_FULL);
      end
      rd_en[v] = valid_sel_i && (vc_sel_i == VC_SIZE'(v)) && (state_q[v] == ACTIVE)
                 && (cnt_q[v] != '0);
      front_last[v] = (mem_q[v][rd_ptr_q[v]].flit_label == TAIL)
                      || (mem_q[v][rd_ptr_q[v]].flit_label == HEADTAIL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v]    <= IDLE;
        rd_ptr_q[v]   <= '0;
        wr_ptr_q[v]   <= '0;
        cnt_q[v]      <= '0;
        down_vc_q[v]  <= '0;
        out_port_q[v] <= LOCAL;
      end
      tail_in_q <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (wr_en[v]) begin
          wr_ptr_q[v] <= (wr_ptr_q[v] == PTR_LAST) ? '0 : wr_ptr_q[v] + PTR_W'(1);
          if (state_q[v] == IDLE) begin
            out_port_q[v] <= route;
            tail_in_q[v]  <= (data_i.flit_label == HEADTAIL);
          end else if (data_i.flit_label == TAIL) begin
            tail_in_q[v] <= 1'b1;
          end
        end
        if (rd_en[v]) rd_ptr_q[v] <= (rd_ptr_q[v] == PTR_LAST) ? '0 : rd_ptr_q[v] + PTR_W'(1);
        case (state_q[v])
          IDLE:    if (wr_en[v]) state_q[v] <= VA;
          VA:      if (vc_valid_i[v]) begin
                     down_vc_q[v] <= vc_new_i[v];
                     state_q[v]   <= ACTIVE;
                   end
          ACTIVE:  if (rd_en[v] && front_last[v]) state_q[v] <= IDLE;
          default: state_q[v] <= IDLE;
        endcase
        case ({wr_en[v], rd_en[v]})
          2'b10:   cnt_q[v] <= cnt_q[v] + CNT_W'(1);
          2'b01:   cnt_q[v] <= cnt_q[v] - CNT_W'(1);
          default: cnt_q[v] <= cnt_q[v];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= data_i;
    end
  end

  always_comb begin
    flit_o = '0;
    if (cnt_q[vc_sel_i] != '0) begin
      flit_o       = mem_q[vc_sel_i][rd_ptr_q[vc_sel_i]];
      flit_o.vc_id = down_vc_q[vc_sel_i];
    end
    for (int v = 0; v < VC_NUM; v++) begin
      is_empty_o[v]       = (cnt_q[v] == '0);
      is_full_o[v]        = (cnt_q[v] == CNT_FULL);
      on_off_o[v]         = (BUFFER_SIZE - int'(cnt_q[v])) >= PIPELINE_DEPTH;
      vc_allocatable_o[v] = (state_q[v] == IDLE);
      vc_request_o[v]     = (state_q[v] == VA);
      out_port_o[v]       = out_port_q[v];
    end
  end

`ifdef INPUT_PORT_PROTOCOL_CHECK_EN
  always @(posedge clk) begin
    if (rst) begin
      if (valid_flit_i && !wr_en[data_i.vc_id]) begin
        if (state_q[data_i.vc_id] == IDLE)
          $error("input_port: BODY/TAIL flit on idle VC %0d dropped", data_i.vc_id);
        else if (is_head)
          $error("input_port: HEAD flit on busy VC %0d dropped", data_i.vc_id);
        else if (cnt_q[data_i.vc_id] == CNT_FULL)
          $error("input_port: write to full VC %0d dropped", data_i.vc_id);
      end
      if (valid_sel_i && !rd_en[vc_sel_i])
        $error("input_port: pop of empty or non-active VC %0d ignored", vc_sel_i);
    end
  end
`endif

endmodule

// File: tb/tb_input_port.sv
// Bench for input_port: route table, directed packet sequences with a scoreboard, and random
// traffic checked every cycle against a queue-based reference model.
module tb_input_port;
  import noc_params::*;

  localparam int BUFFER_SIZE    = 8;
  localparam int PIPELINE_DEPTH = 5;
  localparam int XC             = MESH_SIZE_X / 2;
  localparam int YC             = MESH_SIZE_Y / 2;
  localparam int FW             = $bits(flit_t);

  logic                           clk = 1'b0;
  logic                           rst = 1'b0;
  flit_t                          data_i;
  logic                           valid_flit_i;
  logic [VC_SIZE-1:0]             vc_sel_i;
  logic                           valid_sel_i;
  logic [VC_NUM-1:0][VC_SIZE-1:0] vc_new_i;
  logic [VC_NUM-1:0]              vc_valid_i;
  flit_t                          flit_o;
  logic [VC_NUM-1:0]              on_off_o;
  logic [VC_NUM-1:0]              vc_allocatable_o;
  logic [VC_NUM-1:0]              vc_request_o;
  port_t [VC_NUM-1:0]             out_port_o;
  logic [VC_NUM-1:0]              is_full_o;
  logic [VC_NUM-1:0]              is_empty_o;

  input_port #(
    .BUFFER_SIZE(BUFFER_SIZE), .PIPELINE_DEPTH(PIPELINE_DEPTH), .X_CURRENT(XC), .Y_CURRENT(YC)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i),
    .vc_sel_i(vc_sel_i), .valid_sel_i(valid_sel_i), .vc_new_i(vc_new_i),
    .vc_valid_i(vc_valid_i), .flit_o(flit_o), .on_off_o(on_off_o),
    .vc_allocatable_o(vc_allocatable_o), .vc_request_o(vc_request_o),
    .out_port_o(out_port_o), .is_full_o(is_full_o), .is_empty_o(is_empty_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: one flit queue and packet mode per VC ----------------
  flit_t              mq     [VC_NUM][$];
  int                 m_mode [VC_NUM];   // 0 free, 1 awaiting VC grant, 2 forwarding
  bit                 m_tail [VC_NUM];
  logic [VC_SIZE-1:0] m_dvc  [VC_NUM];
  port_t              m_port [VC_NUM];
  logic [FW-1:0]      exp_q[$];

  function automatic port_t xy_route(input int x, input int y);
    if (x != XC) return (x > XC) ? EAST : WEST;
    if (y != YC) return (y > YC) ? SOUTH : NORTH;
    return LOCAL;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VC_NUM; v++) begin
      mq[v].delete();
      m_mode[v] = 0;
      m_tail[v] = 1'b0;
      m_dvc[v]  = '0;
      m_port[v] = LOCAL;
    end
  endtask

  task automatic model_step();
    int v, s;
    bit hd, acc, pr;
    flit_t f;
    v   = int'(data_i.vc_id);
    s   = int'(vc_sel_i);
    hd  = data_i.flit_label inside {HEAD, HEADTAIL};
    acc = 1'b0;
    if (valid_flit_i) begin
      if (m_mode[v] == 0) acc = hd;
      else acc = !hd && !m_tail[v] && (mq[v].size() < BUFFER_SIZE);
    end
    pr = valid_sel_i && (m_mode[s] == 2) && (mq[s].size() > 0);
    for (int i = 0; i < VC_NUM; i++) begin
      if (m_mode[i] == 1 && vc_valid_i[i]) begin
        m_mode[i] = 2;
        m_dvc[i]  = vc_new_i[i];
      end
    end
    if (pr) begin
      f = mq[s].pop_front();
      if (f.flit_label inside {TAIL, HEADTAIL}) m_mode[s] = 0;
    end
    if (acc) begin
      mq[v].push_back(data_i);
      if (hd) begin
        m_mode[v] = 1;
        m_port[v] = xy_route(int'(data_i.data.head_data.x_dest), int'(data_i.data.head_data.y_dest));
        m_tail[v] = (data_i.flit_label == HEADTAIL);
      end else if (data_i.flit_label == TAIL) begin
        m_tail[v] = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [VC_NUM-1:0] e_empty, e_full, e_onoff, e_alloc, e_req;
    port_t [VC_NUM-1:0] e_port;
    flit_t e_flit;
    int s;
    for (int v = 0; v < VC_NUM; v++) begin
      e_empty[v] = (mq[v].size() == 0);
      e_full[v]  = (mq[v].size() == BUFFER_SIZE);
      e_onoff[v] = (BUFFER_SIZE - mq[v].size()) >= PIPELINE_DEPTH;
      e_alloc[v] = (m_mode[v] == 0);
      e_req[v]   = (m_mode[v] == 1);
      e_port[v]  = m_port[v];
    end
    s = int'(vc_sel_i);
    e_flit = '0;
    if (mq[s].size() > 0) begin
      e_flit       = mq[s][0];
      e_flit.vc_id = m_dvc[s];
    end
    chk({tag, " is_empty_o"}, 64'(is_empty_o), 64'(e_empty));
    chk({tag, " is_full_o"}, 64'(is_full_o), 64'(e_full));
    chk({tag, " on_off_o"}, 64'(on_off_o), 64'(e_onoff));
    chk({tag, " vc_allocatable_o"}, 64'(vc_allocatable_o), 64'(e_alloc));
    chk({tag, " vc_request_o"}, 64'(vc_request_o), 64'(e_req));
    chk({tag, " out_port_o"}, 64'(out_port_o), 64'(e_port));
    chk({tag, " flit_o"}, 64'(flit_o), 64'(e_flit));
  endtask

  // ---------------- driver tasks ----------------
  function automatic flit_t mk(input flit_label_t lbl, input int vc, input int x, input int y,
                               input int pl);
    flit_t f;
    f = '0;
    f.flit_label = lbl;
    f.vc_id      = VC_SIZE'(vc);
    if (lbl inside {HEAD, HEADTAIL}) begin
      f.data.head_data.x_dest  = DEST_ADDR_SIZE_X'(x);
      f.data.head_data.y_dest  = DEST_ADDR_SIZE_Y'(y);
      f.data.head_data.head_pl = HEAD_PAYLOAD_SIZE'(pl);
    end else begin
      f.data.bt_pl = FLIT_DATA_SIZE'(pl);
    end
    return f;
  endfunction

  task automatic idle_in();
    valid_flit_i = 1'b0;
    valid_sel_i  = 1'b0;
    vc_valid_i   = '0;
    vc_new_i     = '0;
    vc_sel_i     = '0;
    data_i       = '0;
  endtask

  task automatic put(input flit_label_t lbl, input int vc, input int x, input int y, input int pl);
    data_i       = mk(lbl, vc, x, y, pl);
    valid_flit_i = 1'b1;
  endtask

  task automatic grant(input int vc, input int new_vc);
    vc_valid_i[vc] = 1'b1;
    vc_new_i[vc]   = VC_SIZE'(new_vc);
  endtask

  // Called at posedge+1; inputs already set for this cycle.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
    valid_flit_i = 1'b0;
    valid_sel_i  = 1'b0;
    vc_valid_i   = '0;
  endtask

  // Request a pop of vc; when the model says it takes effect, score the presented flit.
  task automatic pop_sb(input int vc, input string tag);
    vc_sel_i    = VC_SIZE'(vc);
    valid_sel_i = 1'b1;
    #1;
    if (m_mode[vc] == 2 && mq[vc].size() > 0) begin
      if (exp_q.size() == 0) chk({tag, " unexpected pop"}, 64'(1), 64'(0));
      else chk({tag, " popped flit"}, 64'(flit_o), 64'(exp_q.pop_front()));
    end
  endtask

  typedef struct {
    int    x;
    int    y;
    int    new_vc;
    port_t exp_port;
  } route_vec_t;

  route_vec_t rv[6];
  bit saw_off;

  initial begin
    idle_in();
    model_reset();
    rv[0] = '{XC,     YC,     2, LOCAL};
    rv[1] = '{XC + 1, 0,      1, EAST};
    rv[2] = '{XC - 1, YC + 1, 3, WEST};
    rv[3] = '{XC,     YC + 1, 0, SOUTH};
    rv[4] = '{XC,     YC - 1, 2, NORTH};
    rv[5] = '{0,      0,      1, WEST};

    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset is_empty_o", 64'(is_empty_o), 64'({VC_NUM{1'b1}}));
    chk("reset on_off_o", 64'(on_off_o), 64'({VC_NUM{1'b1}}));
    rst = 1'b1;

    // Single-flit packets through every route direction on VC0.
    for (int i = 0; i < 6; i++) begin
      put(HEADTAIL, 0, rv[i].x, rv[i].y, 16 + i);
      cycle("route write");
      chk("route out_port_o[0]", 64'(out_port_o[0]), 64'(rv[i].exp_port));
      chk("route vc_request_o[0]", 64'(vc_request_o[0]), 64'(1));
      grant(0, rv[i].new_vc);
      cycle("route grant");
      exp_q.push_back(mk(HEADTAIL, rv[i].new_vc, rv[i].x, rv[i].y, 16 + i));
      pop_sb(0, "route");
      cycle("route pop");
      chk("route vc_allocatable_o[0]", 64'(vc_allocatable_o[0]), 64'(1));
    end

    // Four-flit packet on VC1 heading east, grant to downstream VC2, pop every cycle.
    put(HEAD, 1, XC + 1, 1, 'h21);
    cycle("pkt4");
    put(BODY, 1, 0, 0, 'hB1);
    cycle("pkt4");
    put(BODY, 1, 0, 0, 'hB2);
    grant(1, 2);
    cycle("pkt4");
    exp_q.push_back(mk(HEAD, 2, XC + 1, 1, 'h21));
    exp_q.push_back(mk(BODY, 2, 0, 0, 'hB1));
    exp_q.push_back(mk(BODY, 2, 0, 0, 'hB2));
    exp_q.push_back(mk(TAIL, 2, 0, 0, 'hC1));
    put(TAIL, 1, 0, 0, 'hC1);
    pop_sb(1, "pkt4");
    cycle("pkt4");
    for (int i = 0; i < 4; i++) begin
      pop_sb(1, "pkt4");
      cycle("pkt4");
    end
    chk("pkt4 all flits out", 64'(exp_q.size()), 64'(0));
    chk("pkt4 out_port_o[1]", 64'(out_port_o[1]), 64'(EAST));
    chk("pkt4 vc_allocatable_o[1]", 64'(vc_allocatable_o[1]), 64'(1));

    // Sixteen-flit packet on VC2 under on/off flow control.
    exp_q.delete();
    saw_off = 1'b0;
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 200 && (sent < 16 || exp_q.size() > 0); c++) begin
        if (!on_off_o[2]) saw_off = 1'b1;
        if (sent < 16 && on_off_o[2]) begin
          if (sent == 0) begin
            put(HEAD, 2, 0, YC, 'h300);
            exp_q.push_back(mk(HEAD, 1, 0, YC, 'h300));
          end else begin
            put((sent == 15) ? TAIL : BODY, 2, 0, 0, 'h300 + sent);
            exp_q.push_back(mk((sent == 15) ? TAIL : BODY, 1, 0, 0, 'h300 + sent));
          end
          sent++;
        end
        if (c == 5) grant(2, 1);
        if (c >= 7) pop_sb(2, "pkt16");
        cycle("pkt16");
      end
      chk("pkt16 flits sent", 64'(sent), 64'(16));
    end
    chk("pkt16 all flits out", 64'(exp_q.size()), 64'(0));
    chk("pkt16 on_off dropped", 64'(saw_off), 64'(1));
    chk("pkt16 vc_allocatable_o[2]", 64'(vc_allocatable_o[2]), 64'(1));

    // Overfill VC3 without flow control: extra writes are dropped once full.
    exp_q.delete();
    put(HEAD, 3, XC, YC, 'h40);
    exp_q.push_back(mk(HEAD, 3, XC, YC, 'h40));
    cycle("full");
    for (int i = 1; i <= 10; i++) begin
      put(BODY, 3, 0, 0, 'h40 + i);
      if (i < BUFFER_SIZE) exp_q.push_back(mk(BODY, 3, 0, 0, 'h40 + i));
      cycle("full");
    end
    chk("full is_full_o[3]", 64'(is_full_o[3]), 64'(1));
    chk("full on_off_o[3]", 64'(on_off_o[3]), 64'(0));
    grant(3, 3);
    cycle("full grant");
    put(TAIL, 3, 0, 0, 'h4F);
    pop_sb(3, "full");
    cycle("full");
    for (int i = 0; i < BUFFER_SIZE - 1; i++) begin
      pop_sb(3, "full");
      cycle("full");
    end
    chk("full drained", 64'(is_empty_o[3]), 64'(1));
    chk("full still active", 64'(vc_allocatable_o[3]), 64'(0));
    put(TAIL, 3, 0, 0, 'h4E);
    exp_q.push_back(mk(TAIL, 3, 0, 0, 'h4E));
    cycle("full tail");
    pop_sb(3, "full");
    cycle("full tail pop");
    chk("full vc_allocatable_o[3]", 64'(vc_allocatable_o[3]), 64'(1));

    // Repeated HEADs on a busy VC are dropped: only 4 of 6 flits are buffered.
    exp_q.delete();
    put(HEAD, 0, XC + 1, YC, 'h51);
    exp_q.push_back(mk(HEAD, 3, XC + 1, YC, 'h51));
    cycle("dup");
    put(HEAD, 0, 0, 0, 'h52);
    cycle("dup");
    put(HEAD, 0, 0, 0, 'h53);
    cycle("dup");
    put(BODY, 0, 0, 0, 'h54);
    exp_q.push_back(mk(BODY, 3, 0, 0, 'h54));
    cycle("dup");
    put(BODY, 0, 0, 0, 'h55);
    exp_q.push_back(mk(BODY, 3, 0, 0, 'h55));
    cycle("dup");
    put(TAIL, 0, 0, 0, 'h56);
    exp_q.push_back(mk(TAIL, 3, 0, 0, 'h56));
    grant(0, 3);
    cycle("dup");
    begin
      int n_pop;
      n_pop = 0;
      for (int i = 0; i < 8; i++) begin
        if (m_mode[0] == 2 && mq[0].size() > 0) n_pop++;
        pop_sb(0, "dup");
        cycle("dup");
      end
      chk("dup flits read", 64'(n_pop), 64'(4));
    end
    chk("dup out_port_o[0]", 64'(out_port_o[0]), 64'(EAST));

    // BODY and TAIL with no preceding HEAD are discarded.
    put(BODY, 0, 0, 0, 'h61);
    cycle("stray");
    put(TAIL, 0, 0, 0, 'h62);
    cycle("stray");
    chk("stray is_empty_o[0]", 64'(is_empty_o[0]), 64'(1));
    chk("stray vc_request_o[0]", 64'(vc_request_o[0]), 64'(0));

    // Asynchronous reset with three flits buffered on an active VC.
    put(HEAD, 1, 0, 0, 'h71);
    cycle("rst pkt");
    put(BODY, 1, 0, 0, 'h72);
    grant(1, 3);
    cycle("rst pkt");
    put(BODY, 1, 0, 0, 'h73);
    cycle("rst pkt");
    chk("rst pre is_empty_o[1]", 64'(is_empty_o[1]), 64'(0));
    vc_sel_i = VC_SIZE'(1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_model("in reset");
    chk("rst is_empty_o[1]", 64'(is_empty_o[1]), 64'(1));
    chk("rst vc_allocatable_o[1]", 64'(vc_allocatable_o[1]), 64'(1));
    chk("rst flit_o", 64'(flit_o), 64'(0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    put(HEAD, 1, XC, 0, 'h74);
    cycle("post rst");
    chk("post rst vc_request_o[1]", 64'(vc_request_o[1]), 64'(1));
    chk("post rst out_port_o[1]", 64'(out_port_o[1]), 64'(NORTH));

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      int r;
      flit_label_t lbl;
      if ($urandom_range(0, 99) < 60) begin
        r = $urandom_range(0, 99);
        lbl = (r < 20) ? HEAD : (r < 60) ? BODY : (r < 85) ? TAIL : HEADTAIL;
        put(lbl, $urandom_range(0, VC_NUM - 1), $urandom_range(0, MESH_SIZE_X - 1),
            $urandom_range(0, MESH_SIZE_Y - 1), $urandom_range(0, 'hFFFF));
      end
      vc_valid_i = VC_NUM'($urandom_range(0, (1 << VC_NUM) - 1));
      for (int i = 0; i < VC_NUM; i++) vc_new_i[i] = VC_SIZE'($urandom_range(0, VC_NUM - 1));
      vc_sel_i    = VC_SIZE'($urandom_range(0, VC_NUM - 1));
      valid_sel_i = ($urandom_range(0, 99) < 50);
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_port.md
INPUT_PORT -- requirements
Module: input_port

Interface
REQ-001 SHALL have parameters (name, default, meaning): BUFFER_SIZE 8, flits per VC FIFO; PIPELINE_DEPTH 5, upstream round-trip slots reserved for on/off flow control; X_CURRENT MESH_SIZE_X/2, router X coordinate; Y_CURRENT MESH_SIZE_Y/2, router Y coordinate.
REQ-002 SHALL use noc_params types: flit_t, with flit_label ∈ {HEAD, BODY, TAIL, HEADTAIL}, vc_id, and data.head_data.{x_dest, y_dest, head_pl} / data.bt_pl; port_t ∈ {LOCAL, NORTH, SOUTH, WEST, EAST}.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- data_i, in, flit_t, incoming flit.
- valid_flit_i, in, 1, data_i valid this cycle.
- vc_sel_i, in, VC_SIZE, VC selected by switch allocation.
- valid_sel_i, in, 1, pop the front flit of vc_sel_i.
- vc_new_i, in, VC_NUM x VC_SIZE, downstream VC granted per VC.
- vc_valid_i, in, VC_NUM, VA grant strobe per VC.
- flit_o, out, flit_t, front flit of vc_sel_i.
- on_off_o, out, VC_NUM, upstream flow-control enable.
- vc_allocatable_o, out, VC_NUM, VC is free for a new packet.
- vc_request_o, out, VC_NUM, VC is requesting VA.
- out_port_o, out, VC_NUM x port_t, routed output port.
- is_full_o, out, VC_NUM, FIFO full.
- is_empty_o, out, VC_NUM, FIFO empty.

Function
REQ-004 SHALL contain VC_NUM independent FIFOs of BUFFER_SIZE flits; data_i.vc_id selects the target FIFO; the write takes effect at the rising clk edge where valid_flit_i=1.
REQ-005 Each VC SHALL run an FSM with states IDLE, VA, ACTIVE; reset state is IDLE.
REQ-006 IDLE: a HEAD or HEADTAIL flit is stored, its route is latched into out_port_o[v], and the state goes to VA; BODY/TAIL flits are dropped and the FIFO stays empty.
REQ-007 Route SHALL be XY: x_dest>X_CURRENT→EAST; x_dest<X_CURRENT→WEST; otherwise y_dest>Y_CURRENT→SOUTH; y_dest<Y_CURRENT→NORTH; otherwise LOCAL.
REQ-008 VA and ACTIVE: BODY and TAIL flits are stored. An additional HEAD or HEADTAIL flit for a VC not in IDLE SHALL be dropped, with no state change. Once the packet's TAIL has been stored, further flits are dropped until the VC returns to IDLE.
REQ-009 VA: vc_request_o[v]=1. On vc_valid_i[v]=1 at a clock edge, vc_new_i[v] is latched as the downstream VC and the state goes to ACTIVE. vc_valid_i is ignored in any other state.
REQ-010 flit_o SHALL be combinational: the front entry of FIFO vc_sel_i, with vc_id replaced by the latched downstream VC. It SHALL be all zeros when that FIFO is empty.
REQ-011 valid_sel_i=1 with the selected VC ACTIVE and non-empty SHALL pop one flit at the clock edge. Otherwise the pop is ignored.
REQ-012 Popping a TAIL or HEADTAIL SHALL return the VC to IDLE in the same edge.
REQ-013 A simultaneous write and pop on one VC SHALL both take effect, with occupancy unchanged.
REQ-014 A write to a full FIFO SHALL be dropped. Occupancy saturates at BUFFER_SIZE, and read/write pointers wrap modulo BUFFER_SIZE.
REQ-015 is_full_o/is_empty_o SHALL reflect occupancy registered after the edge.
REQ-016 on_off_o[v]=1 iff free slots ≥ PIPELINE_DEPTH; with defaults this means occupancy ≤ 3.
REQ-017 vc_allocatable_o[v]=1 iff VC v is IDLE.

Reset
REQ-018 rst=0 SHALL asynchronously clear all pointers and occupancy and set every FSM to IDLE. This applies mid-packet too; buffered flits are discarded.
REQ-019 Output values during reset: is_empty_o all 1; is_full_o 0; vc_request_o 0; vc_allocatable_o all 1; on_off_o all 1; out_port_o LOCAL; flit_o zeros; latched downstream VCs 0.

Configuration
REQ-020 Macro INPUT_PORT_PROTOCOL_CHECK_EN defined: simulation $error on write to a full FIFO, dropped HEAD in a non-IDLE VC, BODY/TAIL in IDLE, and pop of an empty/non-ACTIVE VC. Undefined: no checks; the same drop/ignore behaviour with silent handling.

Verification
REQ-021 4-flit packet HEAD/BODY/BODY/TAIL on VC1, x_dest>X_CURRENT, VA grant vc_new=2 after 2 cycles, pops every cycle → flits returned in order with vc_id=2, out_port_o[1]=EAST, VC1 IDLE after TAIL.
REQ-022 HEADTAIL on VC0 with dest=(X_CURRENT,Y_CURRENT), then VA, then one pop → flit_o matches with new vc_id, out_port_o[0]=LOCAL, vc_allocatable_o[0]=1 after pop.
REQ-023 16-flit packet on one VC with pops starting 1 cycle after VA → 16 flits out in order. Writes while full are dropped; on_off_o drops to 0 when occupancy reaches 4.
REQ-024 HEAD, HEAD, HEAD, BODY×2, TAIL → only the first HEAD plus 2 BODY and the TAIL are buffered (4 flits read).
REQ-025 BODY then TAIL to an IDLE VC0 with no HEAD → is_empty_o[0] remains 1, and vc_request_o[0]=0.
REQ-026 rst=0 asserted with 3 flits buffered and the VC ACTIVE → immediately is_empty_o=1 and state IDLE; a subsequent HEAD is accepted normally.
